// File: rtl/score_pkg.sv
// Shared types and default timing for the score button controller.
// Auto-repeat is compiled in only when SCORE_AUTOREPEAT_EN is defined.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } btn_state_e;

    localparam int DEF_DEB_CYCLES    = 20000;
    localparam int DEF_HOLD_CYCLES   = 500000;
    localparam int DEF_REPEAT_CYCLES = 100000;
    localparam int DEF_CLEAR_CYCLES  = 2000000;

    // Counter width able to hold the limit itself.
    function automatic int cnt_w(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/score_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw button.
// Emits the debounced level and one-cycle rise/fall strobes.
module score_debounce
    import score_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count cycles of disagreement; accept the new level once stable long enough.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchroniser, debounce state and strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/score_button_ctrl.sv
// Up/down score buttons: debounced press pulses, optional auto-repeat
// (SCORE_AUTOREPEAT_EN) and a both-held clear request.
module score_button_ctrl
    import score_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CLEAR_CYCLES  = DEF_CLEAR_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_up_i,
    input  logic btn_down_i,
    output logic up_pulse_o,
    output logic down_pulse_o,
    output logic clear_o
);

    localparam int CLW = cnt_w(CLEAR_CYCLES);
    localparam logic [CLW-1:0] CLR_LAST = CLW'(CLEAR_CYCLES - 1);
    localparam logic [CLW-1:0] CLR_MAX  = CLW'(CLEAR_CYCLES);

    if (DEB_CYCLES < 2 || HOLD_CYCLES < 2 ||
        REPEAT_CYCLES < 2 || CLEAR_CYCLES < 1) begin : g_bad_cfg
        $error("score_button_ctrl: timing parameter out of range");
    end

    // Index 0 is the up button, index 1 the down button.
    logic [1:0] lvl, rise, fall, lvl_other;

    score_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (btn_up_i),
        .level_o (lvl[0]),
        .rise_o  (rise[0]),
        .fall_o  (fall[0])
    );

    score_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (btn_down_i),
        .level_o (lvl[1]),
        .rise_o  (rise[1]),
        .fall_o  (fall[1])
    );

    // A pulse is suppressed whenever the other button is also down.
    assign lvl_other = {lvl[0], lvl[1]};

`ifdef SCORE_AUTOREPEAT_EN
    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam int RW = cnt_w(REPEAT_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_CYCLES - 1);

    logic [HW-1:0] hold_q [2];
    logic [RW-1:0] rep_q  [2];
`endif

    btn_state_e state_q [2];
    logic [1:0] pulse_q;

    // Per-button press FSM with registered pulse outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= IDLE;
`ifdef SCORE_AUTOREPEAT_EN
                hold_q[b]  <= '0;
                rep_q[b]   <= '0;
`endif
            end
            pulse_q <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                pulse_q[b] <= 1'b0;
                unique case (state_q[b])
                    IDLE: begin
                        if (rise[b]) begin
                            state_q[b] <= HELD;
                            pulse_q[b] <= ~lvl_other[b];
`ifdef SCORE_AUTOREPEAT_EN
                            hold_q[b]  <= '0;
`endif
                        end
                    end
                    HELD: begin
                        if (fall[b]) begin
                            state_q[b] <= IDLE;
                        end
`ifdef SCORE_AUTOREPEAT_EN
                        else if (hold_q[b] >= HOLD_LAST) begin
                            state_q[b] <= REPEAT;
                            rep_q[b]   <= '0;
                            pulse_q[b] <= ~lvl_other[b];
                        end else begin
                            hold_q[b] <= hold_q[b] + HW'(1);
                        end
`endif
                    end
`ifdef SCORE_AUTOREPEAT_EN
                    REPEAT: begin
                        if (fall[b]) begin
                            state_q[b] <= IDLE;
                        end else if (rep_q[b] >= RPT_LAST) begin
                            rep_q[b]   <= '0;
                            pulse_q[b] <= ~lvl_other[b];
                        end else begin
                            rep_q[b] <= rep_q[b] + RW'(1);
                        end
                    end
`endif
                    default: state_q[b] <= IDLE;
                endcase
            end
        end
    end

    logic           both;
    logic [CLW-1:0] clr_cnt_q;
    logic           clr_done_q;
    logic           clear_q;

    assign both = &lvl;

    // Clear timer: runs while both are held, fires once per both-held episode.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clr_cnt_q  <= '0;
            clr_done_q <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            clear_q <= both && (clr_cnt_q == CLR_LAST) && !clr_done_q;
            if (!both) begin
                clr_cnt_q <= '0;
            end else if (clr_cnt_q != CLR_MAX) begin
                clr_cnt_q <= clr_cnt_q + CLW'(1);
            end
            if (both && (clr_cnt_q == CLR_LAST)) begin
                clr_done_q <= 1'b1;
            end else if (lvl == 2'b00) begin
                clr_done_q <= 1'b0;
            end
        end
    end

    assign up_pulse_o   = pulse_q[0];
    assign down_pulse_o = pulse_q[1];
    assign clear_o      = clear_q;

endmodule

// File: tb/tb_score_button_ctrl.sv
// Directed bench for score_button_ctrl with short timing parameters.
// Expectations follow SCORE_AUTOREPEAT_EN as seen by this compile.
module tb_score_button_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic bu    = 1'b0;
    logic bd    = 1'b0;
    logic up, dn, clr;

    score_button_ctrl #(
        .DEB_CYCLES    (4),
        .HOLD_CYCLES   (20),
        .REPEAT_CYCLES (5),
        .CLEAR_CYCLES  (30)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .btn_up_i     (bu),
        .btn_down_i   (bd),
        .up_pulse_o   (up),
        .down_pulse_o (dn),
        .clear_o      (clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int k = 0;
    int viol = 0;
    int up_t[$];
    int dn_t[$];
    int cl_t[$];
    logic pu = 1'b0, pd = 1'b0, pc = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(input logic u, input logic d);
        bu = u;
        bd = d;
        @(posedge clk);
        #1;
        k++;
        if (up === 1'b1) up_t.push_back(k);
        if (dn === 1'b1) dn_t.push_back(k);
        if (clr === 1'b1) cl_t.push_back(k);
        if (up === 1'b1 && pu) viol++;
        if (dn === 1'b1 && pd) viol++;
        if (clr === 1'b1 && pc) viol++;
        pu = (up === 1'b1);
        pd = (dn === 1'b1);
        pc = (clr === 1'b1);
    endtask

    task automatic run(input logic u, input logic d, input int n);
        repeat (n) step(u, d);
    endtask

    task automatic clr_rec();
        k = 0;
        up_t.delete();
        dn_t.delete();
        cl_t.delete();
    endtask

    function automatic int first(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    int exp_dn[$];
    int late;

    initial begin
`ifdef SCORE_AUTOREPEAT_EN
        exp_dn = '{7, 27, 32, 37, 42, 47, 52};
`else
        exp_dn = '{7};
`endif
        // Reset state
        run(1'b1, 1'b1, 3);
        check("rst_up", int'(up), 0);
        check("rst_dn", int'(dn), 0);
        check("rst_clr", int'(clr), 0);
        rst_n = 1'b1;
        run(1'b0, 1'b0, 10);

        // Case 1: bouncing then stable press
        for (int i = 0; i < 10; i++) step(i % 2 == 0, 1'b0);
        clr_rec();
        run(1'b1, 1'b0, 15);
        check("c1_up_cnt", up_t.size(), 1);
        check("c1_up_time", first(up_t), 7);
        check("c1_dn_cnt", dn_t.size(), 0);
        clr_rec();
        run(1'b0, 1'b0, 15);
        check("c1_release", up_t.size(), 0);

        // Case 2/3: long down press
        clr_rec();
        run(1'b0, 1'b1, 50);
        run(1'b0, 1'b0, 20);
        check("c2_dn_cnt", dn_t.size(), exp_dn.size());
        for (int i = 0; i < exp_dn.size(); i++)
            check("c2_dn_time", (i < dn_t.size()) ? dn_t[i] : -1, exp_dn[i]);
        late = 0;
        foreach (dn_t[i]) if (dn_t[i] > 52) late++;
        check("c2_after_rel", late, 0);
        check("c2_up_cnt", up_t.size(), 0);

        // Case 6: press shorter than debounce
        clr_rec();
        run(1'b1, 1'b0, 3);
        run(1'b0, 1'b0, 15);
        check("c6_up_cnt", up_t.size(), 0);

        // Case 4: both buttons together
        clr_rec();
        run(1'b1, 1'b1, 40);
        run(1'b0, 1'b0, 20);
        check("c4_up_cnt", up_t.size(), 0);
        check("c4_dn_cnt", dn_t.size(), 0);
        check("c4_clr_cnt", cl_t.size(), 1);
        check("c4_clr_time", first(cl_t), 36);

        // Case 5: reset in the middle of a held press
        clr_rec();
        run(1'b1, 1'b0, 32);
`ifdef SCORE_AUTOREPEAT_EN
        check("c5_pre_cnt", up_t.size(), 3);
`else
        check("c5_pre_cnt", up_t.size(), 1);
`endif
        rst_n = 1'b0;
        #1;
        check("c5_async_up", int'(up), 0);
        check("c5_async_clr", int'(clr), 0);
        run(1'b1, 1'b0, 3);
        check("c5_in_rst_up", int'(up), 0);
        rst_n = 1'b1;
        clr_rec();
        run(1'b1, 1'b0, 12);
        check("c5_first", first(up_t), 7);
        check("c5_cnt", up_t.size(), 1);
        run(1'b0, 1'b0, 15);

        check("no_back_to_back", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/score_button_ctrl.md
SCORE_BUTTON_CTRL -- requirements
Module: score_button_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 20000; stable-input cycles required before a debounced level change is accepted (minimum 2).
REQ-002 Parameter HOLD_CYCLES, default 500000; cycles a button is held before auto-repeat starts.
REQ-003 Parameter REPEAT_CYCLES, default 100000; period of auto-repeat pulses.
REQ-004 Parameter CLEAR_CYCLES, default 2000000; cycles both buttons must be held to request a clear.
REQ-005 clk_i  input  1  single system clock.
REQ-006 rst_ni  input  1  asynchronous, active-low reset.
REQ-007 btn_up_i  input  1  raw, asynchronous, bouncing up button, active-high.
REQ-008 btn_down_i  input  1  raw, asynchronous, bouncing down button, active-high.
REQ-009 up_pulse_o  output  1  registered one-cycle count-up request.
REQ-010 down_pulse_o  output  1  registered one-cycle count-down request.
REQ-011 clear_o  output  1  registered one-cycle clear request for the score counter.

Function
REQ-012 Each raw button SHALL pass through a two-flop synchroniser before any other logic.
REQ-013 Per button, a debounce counter SHALL reset whenever the synchronised level equals the debounced level; after DEB_CYCLES consecutive cycles of difference, the debounced level SHALL toggle.
REQ-014 A debounced 0->1 transition SHALL produce exactly one pulse on the matching output, on the cycle after the transition is accepted.
REQ-015 A debounced 1->0 transition SHALL produce no pulse.
REQ-016 If both debounced levels are 1, no up or down pulses SHALL be emitted, including repeats.
REQ-017 If the up and down debounced rises occur in the same cycle, neither pulse SHALL be emitted.
REQ-018 A per-button FSM SHALL use states IDLE, HELD and REPEAT.
REQ-019 IDLE->HELD SHALL occur on the debounced rise, and the initial pulse SHALL be emitted.
REQ-020 HELD->REPEAT SHALL occur after HOLD_CYCLES with the level still 1.
REQ-021 In REPEAT, a pulse SHALL be emitted every REPEAT_CYCLES.
REQ-022 Any state SHALL go to IDLE on a debounced fall.
REQ-023 A clear timer SHALL count while both debounced levels are 1.
REQ-024 When the clear timer reaches CLEAR_CYCLES, clear_o SHALL pulse once; no further clear SHALL be issued until both buttons are released.
REQ-025 Releasing either button SHALL reset the clear timer.
REQ-026 All counters SHALL saturate rather than wrap.
REQ-027 Each counter width SHALL be $clog2 of its limit plus 1.
REQ-028 Outputs SHALL never be high for two consecutive cycles.

Reset
REQ-029 While rst_ni=0, all outputs SHALL be 0, synchroniser and debounced levels SHALL be 0, the FSMs SHALL be in IDLE, and all counters SHALL be 0.
REQ-030 Assertion of rst_ni mid-hold SHALL abort any pending repeat or clear; after release, a button still held SHALL require a full DEB_CYCLES before a pulse.

Configuration
REQ-031 Macro SCORE_AUTOREPEAT_EN defined: the HELD->REPEAT behaviour SHALL be compiled in.
REQ-032 Macro SCORE_AUTOREPEAT_EN undefined: the FSM SHALL remain in HELD until release, only one pulse SHALL be emitted per press, and the repeat counters SHALL be absent.

Structure
REQ-033 Package score_pkg SHALL hold the FSM state typedef (IDLE/HELD/REPEAT) and the default timing constants.
REQ-034 Sub-module score_debounce (synchroniser, debounce counter, debounced level output, rise and fall strobes) SHALL be instantiated once per button.

Verification (DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5, CLEAR_CYCLES=30)
REQ-035 Case 1: btn_up_i toggling every cycle for 10 cycles, then held high -> exactly one up_pulse_o, 2+4+1 cycles after the stable-high start; down_pulse_o stays 0.
REQ-036 Case 2: btn_down_i held for 50 cycles with the macro defined -> pulse at about 7 cycles, then repeats every 5 cycles after the 20-cycle hold; 0 pulses after release.
REQ-037 Case 3: same as case 2 with the macro undefined -> exactly one down_pulse_o.
REQ-038 Case 4: both buttons rise in the same cycle and are held for 40 cycles -> no up or down pulse; exactly one clear_o, about 30 cycles after both are debounced.
REQ-039 Case 5: rst_ni pulsed low mid-repeat -> all outputs 0 immediately; held button gives its first new pulse DEB_CYCLES+3 cycles after rst_ni rises.
REQ-040 Case 6: press is 3 cycles long (< DEB_CYCLES) -> no pulse.
